loop_ctrl: RTL and testbench

Loop sequencer for the perf_sys loop-limit path, placed around the loop limiter stage. It drives the running loop index and the `stop` qualifier into the limiter and consumes the limiter's incremented index and fail flag. It advances one loop per workload completion pulse and ends in DONE when the requested loop count is reached. It ends in FAIL when the limiter reports an over-limit condition or returns an invalid index. An optional counter measures total run cycles for performance reporting.

---
 rtl/loop_ctrl.sv | 165 ++++++++++++++++
 tb/tb_loop_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_ctrl.sv
// Loop sequencer around the loop limiter: steps current_loop on each completed
// iteration and ends in DONE or FAIL. Optional run-cycle counter: LOOP_CTRL_CYCLE_CNT_EN.
module loop_ctrl #(
  parameter int unsigned LIM_LAT = 2,
  parameter int unsigned CYC_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      target_loops,
  input  logic             iter_done,
  input  logic [15:0]      loop_next,
  input  logic             limit_fail,
  output logic [15:0]      current_loop,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LIM_LAT);

  state_t      state_r, state_s;
  logic [15:0] tgt_r, tgt_s;
  logic [3:0]  wcnt_r, wcnt_s;
  logic [15:0] cur_r, cur_s;
  logic [15:0] nxt_s;
  logic        done_r, done_s;
  logic        fail_r, fail_s;
  logic        busy_r, busy_s;
  logic        stop_r, stop_s;
  logic        clr_cnt_s;

  // Next-state and next-output decode for the loop sequencer.
  always_comb begin
    state_s   = state_r;
    tgt_s     = tgt_r;
    wcnt_s    = wcnt_r;
    cur_s     = cur_r;
    done_s    = done_r;
    fail_s    = fail_r;
    clr_cnt_s = 1'b0;
    nxt_s     = cur_r + 16'd1;
    case (state_r)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          tgt_s     = target_loops;
          cur_s     = 16'd0;
          fail_s    = 1'b0;
          clr_cnt_s = 1'b1;
          if (target_loops == 16'd0) begin
            state_s = S_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = S_RUN;
            done_s  = 1'b0;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (limit_fail) begin
          state_s = S_FAIL;
          fail_s  = 1'b1;
        end else if (iter_done) begin
          state_s = S_WAIT;
          wcnt_s  = LAT4;
        end else begin
          state_s = S_RUN;
        end
      end
      S_WAIT: begin
        if (limit_fail) begin
          state_s = S_FAIL;
          fail_s  = 1'b1;
        end else if (wcnt_r <= 4'd1) begin
          // Counter expires this cycle: loop_next is valid, judge it.
          wcnt_s = 4'd0;
          if ((loop_next == 16'd0) || (loop_next != nxt_s)) begin
            state_s = S_FAIL;
            fail_s  = 1'b1;
          end else begin
            cur_s = loop_next;
            if (loop_next == tgt_r) begin
              state_s = S_DONE;
              done_s  = 1'b1;
            end else begin
              state_s = S_RUN;
            end
          end
        end else begin
          wcnt_s = wcnt_r - 4'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s == S_RUN) || (state_s == S_WAIT);
    stop_s = ~busy_s;
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      tgt_r   <= 16'd0;
      wcnt_r  <= 4'd0;
      cur_r   <= 16'd0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
      busy_r  <= 1'b0;
      stop_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      tgt_r   <= tgt_s;
      wcnt_r  <= wcnt_s;
      cur_r   <= cur_s;
      done_r  <= done_s;
      fail_r  <= fail_s;
      busy_r  <= busy_s;
      stop_r  <= stop_s;
    end
  end

  assign current_loop = cur_r;
  assign stop         = stop_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign fail         = fail_r;

`ifdef LOOP_CTRL_CYCLE_CNT_EN
  logic [CYC_W-1:0] cyc_r;

  // Saturating count of cycles spent with busy high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_r <= {CYC_W{1'b0}};
    end else if (clr_cnt_s) begin
      cyc_r <= {CYC_W{1'b0}};
    end else if (busy_r && (cyc_r != {CYC_W{1'b1}})) begin
      cyc_r <= cyc_r + {{(CYC_W-1){1'b0}}, 1'b1};
    end else begin
      cyc_r <= cyc_r;
    end
  end

  assign cycle_count = cyc_r;
`else
  logic unused_clr_s;
  assign unused_clr_s = clr_cnt_s;
  assign cycle_count  = {CYC_W{1'b0}};
`endif

endmodule

// File: tb/tb_loop_ctrl.sv
// Self-checking bench for loop_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-style reference model.
module tb_loop_ctrl;

  localparam int LAT = 2;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   target_loops = 16'd0;
  logic          iter_done = 1'b0;
  logic [15:0]   loop_next = 16'd0;
  logic          limit_fail = 1'b0;
  logic [15:0]   current_loop;
  logic          stop;
  logic          busy;
  logic          done;
  logic          fail;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  loop_ctrl #(.LIM_LAT(LAT), .CYC_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .target_loops(target_loops),
    .iter_done(iter_done), .loop_next(loop_next), .limit_fail(limit_fail),
    .current_loop(current_loop), .stop(stop), .busy(busy), .done(done),
    .fail(fail), .cycle_count(cycle_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a run is active or not; m_wait counts limiter cycles left (0 = ready for work)
  bit          m_active;
  int          m_wait;
  logic [15:0] m_cur;
  logic [15:0] m_tgt;
  bit          m_done;
  bit          m_fail;
  logic [31:0] m_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit st, input logic [15:0] tg, input bit it,
                            input bit lf, input logic [15:0] ln, input bit rs);
    logic [15:0] want;
    want = m_cur + 16'd1;
    if (rs) begin
      m_active = 0; m_wait = 0; m_cur = 16'd0; m_done = 0; m_fail = 0; m_cyc = 32'd0;
    end else if (!m_active) begin
      if (st) begin
        m_tgt = tg; m_cur = 16'd0; m_fail = 0; m_cyc = 32'd0; m_wait = 0;
        m_done   = (tg == 16'd0);
        m_active = (tg != 16'd0);
      end
    end else begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
      if (lf) begin
        m_active = 0; m_fail = 1;
      end else if (m_wait == 0) begin
        if (it) m_wait = LAT;
      end else begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          if (ln == 16'd0 || ln != want) begin
            m_active = 0; m_fail = 1;
          end else begin
            m_cur = ln;
            if (ln == m_tgt) begin
              m_active = 0; m_done = 1;
            end
          end
        end
      end
    end
  endtask

  // One clock: drive inputs just after a falling edge, update the model, check at the next falling edge.
  // ln_mode: 0 = correct index+1, 1 = returns 0, 2 = returns index+2.
  task automatic tick(input bit st, input logic [15:0] tg, input bit it, input bit lf,
                      input int ln_mode, input bit rs);
    logic [15:0] ln;
    logic [31:0] exp_cyc;
    case (ln_mode)
      1:       ln = 16'd0;
      2:       ln = current_loop + 16'd2;
      default: ln = current_loop + 16'd1;
    endcase
    reset = rs; start = st; target_loops = tg; iter_done = it; limit_fail = lf; loop_next = ln;
    model_step(st, tg, it, lf, ln, rs);
    @(negedge clk);
`ifdef LOOP_CTRL_CYCLE_CNT_EN
    exp_cyc = m_cyc;
`else
    exp_cyc = 32'd0;
`endif
    check_eq("current_loop", {16'd0, current_loop}, {16'd0, m_cur});
    check_eq("busy", {31'd0, busy}, {31'd0, m_active});
    check_eq("stop", {31'd0, stop}, {31'd0, !m_active});
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("fail", {31'd0, fail}, {31'd0, m_fail});
    check_eq("cycle_count", cycle_count, exp_cyc);
  endtask

  // Drive iter_done every 4th cycle until the run ends, optionally injecting limit_fail
  // with the lf_at-th iter_done, or a zero loop_next during the zero_at-th wait.
  task automatic run_seq(input int max_t, input int lf_at, input int zero_at, input int stop_cur);
    int  iters;
    bit  it;
    bit  lf;
    iters = 0;
    for (int t = 0; t < max_t && m_active && int'(m_cur) != stop_cur; t++) begin
      it = ((t % 4) == 1);
      if (it && m_wait == 0) iters++;
      lf = it && (iters == lf_at) && (m_wait == 0);
      tick(1'b0, 16'd0, it, lf, (iters == zero_at) ? 1 : 0, 1'b0);
    end
  endtask

  initial begin
    bit st, it, lf, rs;
    int mode;
    logic [15:0] tg;
    logic [31:0] exp12;

    @(negedge clk);
    tick(1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b1);
    tick(1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    check_eq("rst_stop", {31'd0, stop}, 32'd1);
    check_eq("rst_cur", {16'd0, current_loop}, 32'd0);

    // Target 3, clean limiter
    tick(1'b1, 16'd3, 1'b0, 1'b0, 0, 1'b0);
    check_eq("t3_busy_after_start", {31'd0, busy}, 32'd1);
    run_seq(60, -1, -1, -1);
    check_eq("t3_cur", {16'd0, current_loop}, 32'd3);
    check_eq("t3_done", {31'd0, done}, 32'd1);
`ifdef LOOP_CTRL_CYCLE_CNT_EN
    exp12 = 32'd12;
`else
    exp12 = 32'd0;
`endif
    check_eq("t3_cycles", cycle_count, exp12);
    tick(1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b0);

    // Target 0 completes immediately
    tick(1'b1, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    check_eq("t0_done", {31'd0, done}, 32'd1);
    check_eq("t0_busy", {31'd0, busy}, 32'd0);
    tick(1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b0);

    // Target 10, limit_fail together with the 4th iter_done
    tick(1'b1, 16'd10, 1'b0, 1'b0, 0, 1'b0);
    run_seq(100, 4, -1, -1);
    check_eq("lf_fail", {31'd0, fail}, 32'd1);
    check_eq("lf_cur", {16'd0, current_loop}, 32'd3);
    check_eq("lf_stop", {31'd0, stop}, 32'd1);

    // Target 10, zero index at the 2nd evaluation
    tick(1'b1, 16'd10, 1'b0, 1'b0, 0, 1'b0);
    run_seq(100, -1, 2, -1);
    check_eq("zero_fail", {31'd0, fail}, 32'd1);
    check_eq("zero_cur", {16'd0, current_loop}, 32'd1);

    // Mid-run reset at loop 5, then a normal target-2 run
    tick(1'b1, 16'd10, 1'b0, 1'b0, 0, 1'b0);
    run_seq(100, -1, -1, 5);
    check_eq("mid_cur5", {16'd0, current_loop}, 32'd5);
    tick(1'b0, 16'd0, 1'b1, 1'b0, 0, 1'b1);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_cur", {16'd0, current_loop}, 32'd0);
    tick(1'b1, 16'd2, 1'b0, 1'b0, 0, 1'b0);
    run_seq(60, -1, -1, -1);
    check_eq("mid_t2_done", {31'd0, done}, 32'd1);
    check_eq("mid_t2_cur", {16'd0, current_loop}, 32'd2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      st   = ($urandom_range(0, 15) == 0);
      tg   = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      it   = ($urandom_range(0, 1) == 1);
      lf   = ($urandom_range(0, 63) == 0);
      mode = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 2)) : 0;
      rs   = ($urandom_range(0, 499) == 0);
      tick(st, tg, it, lf, mode, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
